// File: rtl/bus_datapath_seq.sv
// Single-bus CPU datapath with an internal micro-step sequencer: general registers,
// Y, ZHI/ZLO, HI and MDR share one bus, and commands run one at a time.
module bus_datapath_seq #(
    parameter int WIDTH   = 32,
    parameter int NREGS   = 16,
    parameter int R0_ZERO = 0
) (
    input  logic                     clock,
    input  logic                     clear,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [2:0]               cmd_op,
    input  logic [$clog2(NREGS)-1:0] cmd_rd,
    input  logic [$clog2(NREGS)-1:0] cmd_rs,
    input  logic [$clog2(NREGS)-1:0] cmd_rt,
    input  logic [WIDTH-1:0]         cmd_imm,
    output logic                     done,
    output logic                     busy,
    output logic [WIDTH-1:0]         hi_out,
    output logic [WIDTH-1:0]         bus_out,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [WIDTH-1:0]         mem_addr,
    output logic [WIDTH-1:0]         mem_wdata,
    input  logic [WIDTH-1:0]         mem_rdata,
    input  logic                     mem_ack,
    input  logic [$clog2(NREGS)-1:0] dbg_sel,
    output logic [WIDTH-1:0]         dbg_data
);

    localparam int AW = $clog2(NREGS);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam bit R0Z = (R0_ZERO != 0);

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_OR   = 3'd3;
    localparam logic [2:0] OP_MUL  = 3'd4;
    localparam logic [2:0] OP_MOVI = 3'd5;
    localparam logic [2:0] OP_LD   = 3'd6;
    localparam logic [2:0] OP_ST   = 3'd7;

    typedef enum logic [2:0] {IDLE, TY, TALU, TMUL, TMEM, TWB} state_t;

    state_t            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [AW-1:0]     rd_q, rd_d, rs_q, rs_d, rt_q, rt_d;
    logic [WIDTH-1:0]  imm_q, imm_d;
    logic [WIDTH-1:0]  y_q, y_d, zhi_q, zhi_d, zlo_q, zlo_d;
    logic [WIDTH-1:0]  hi_q, hi_d, mdr_q, mdr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              done_q, done_d;
    logic [WIDTH-1:0]  regs_q [NREGS];
    logic [WIDTH-1:0]  regs_d [NREGS];

    logic [WIDTH-1:0]  bus;
    logic [WIDTH-1:0]  rs_val, rt_val;
    logic [WIDTH:0]    mul_sum;

    assign rs_val   = (R0Z && rs_q == '0) ? '0 : regs_q[rs_q];
    assign rt_val   = (R0Z && rt_q == '0) ? '0 : regs_q[rt_q];
    assign dbg_data = (R0Z && dbg_sel == '0) ? '0 : regs_q[dbg_sel];

    // One shift-add step: ZLO holds the remaining multiplier bits, ZHI the running partial product.
    assign mul_sum = {1'b0, zhi_q} + (zlo_q[0] ? {1'b0, y_q} : {(WIDTH+1){1'b0}});

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        rd_d    = rd_q;
        rs_d    = rs_q;
        rt_d    = rt_q;
        imm_d   = imm_q;
        y_d     = y_q;
        zhi_d   = zhi_q;
        zlo_d   = zlo_q;
        hi_d    = hi_q;
        mdr_d   = mdr_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        regs_d  = regs_q;
        bus     = '0;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    op_d  = cmd_op;
                    rd_d  = cmd_rd;
                    rs_d  = cmd_rs;
                    rt_d  = cmd_rt;
                    imm_d = cmd_imm;
                    case (cmd_op)
                        OP_MOVI:      state_d = TWB;
                        OP_LD, OP_ST: state_d = TMEM;
                        default:      state_d = TY;
                    endcase
                end
            end
            TY: begin
                bus = rs_val;
                y_d = bus;
                if (op_q == OP_MUL) begin
                    zhi_d   = '0;
                    zlo_d   = rt_val;
                    cnt_d   = '0;
                    state_d = TMUL;
                end else begin
                    state_d = TALU;
                end
            end
            TALU: begin
                bus   = rt_val;
                zhi_d = '0;
                case (op_q)
                    OP_ADD:  zlo_d = y_q + bus;
                    OP_SUB:  zlo_d = y_q - bus;
                    OP_AND:  zlo_d = y_q & bus;
                    default: zlo_d = y_q | bus;
                endcase
                state_d = TWB;
            end
            TMUL: begin
                bus   = rt_val;
                zhi_d = mul_sum[WIDTH:1];
                zlo_d = {mul_sum[0], zlo_q[WIDTH-1:1]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = TWB;
                end
            end
            TMEM: begin
                if (mem_ack) begin
                    if (op_q == OP_LD) begin
                        mdr_d = mem_rdata;
                    end
                    state_d = TWB;
                end
            end
            TWB: begin
                case (op_q)
                    OP_MOVI: bus = imm_q;
                    OP_LD:   bus = mdr_q;
                    OP_ST:   bus = '0;
                    default: bus = zlo_q;
                endcase
                if (op_q != OP_ST && !(R0Z && rd_q == '0)) begin
                    regs_d[rd_q] = bus;
                end
                if (op_q == OP_MUL) begin
                    hi_d = zhi_q;
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q <= IDLE;
            op_q    <= '0;
            rd_q    <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            imm_q   <= '0;
            y_q     <= '0;
            zhi_q   <= '0;
            zlo_q   <= '0;
            hi_q    <= '0;
            mdr_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            rd_q    <= rd_d;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
            imm_q   <= imm_d;
            y_q     <= y_d;
            zhi_q   <= zhi_d;
            zlo_q   <= zlo_d;
            hi_q    <= hi_d;
            mdr_q   <= mdr_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            regs_q  <= regs_d;
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign busy      = ~cmd_ready;
    assign done      = done_q;
    assign hi_out    = hi_q;
    assign bus_out   = bus;
    assign mem_req   = (state_q == TMEM);
    assign mem_we    = mem_req && (op_q == OP_ST);
    assign mem_addr  = rs_val;
    assign mem_wdata = rt_val;

endmodule

// File: tb/tb_bus_datapath_seq.sv
// Self-checking bench for bus_datapath_seq: directed scenarios then random commands,
// compared against an array-based architectural model of the register file.
module tb_bus_datapath_seq;

    localparam int WIDTH = 32;
    localparam int NREGS = 16;

    logic              clock, clear;
    logic              cmd_valid, cmd_ready;
    logic [2:0]        cmd_op;
    logic [3:0]        cmd_rd, cmd_rs, cmd_rt;
    logic [WIDTH-1:0]  cmd_imm;
    logic              done, busy;
    logic [WIDTH-1:0]  hi_out, bus_out;
    logic              mem_req, mem_we;
    logic [WIDTH-1:0]  mem_addr, mem_wdata, mem_rdata;
    logic              mem_ack;
    logic [3:0]        dbg_sel;
    logic [WIDTH-1:0]  dbg_data;

    int testCount = 0;
    int failCount = 0;

    logic [WIDTH-1:0]  mReg [NREGS];
    logic [WIDTH-1:0]  mHi;

    bus_datapath_seq #(.WIDTH(WIDTH), .NREGS(NREGS), .R0_ZERO(1)) dut (
        .clock(clock), .clear(clear),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_rd(cmd_rd), .cmd_rs(cmd_rs), .cmd_rt(cmd_rt), .cmd_imm(cmd_imm),
        .done(done), .busy(busy), .hi_out(hi_out), .bus_out(bus_out),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .dbg_sel(dbg_sel), .dbg_data(dbg_data)
    );

    initial clock = 1'b0;
    always #50 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [WIDTH-1:0] observed,
                               input logic [WIDTH-1:0] expected);
        testCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #5;
    endtask

    task automatic readReg(input int idx, output logic [WIDTH-1:0] v);
        dbg_sel = idx[3:0];
        #1;
        v = dbg_data;
    endtask

    task automatic checkAllRegs(input string tag);
        logic [WIDTH-1:0] v;
        for (int i = 0; i < NREGS; i++) begin
            readReg(i, v);
            checkOutput($sformatf("%s_r%0d", tag, i), v, mReg[i]);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < NREGS; i++) mReg[i] = '0;
        mHi = '0;
    endtask

    // Architectural effect of one retired command; R0 is hardwired to zero.
    task automatic modelExec(input logic [2:0] op, input logic [3:0] rd, rs, rt,
                             input logic [WIDTH-1:0] imm, rdata);
        logic [WIDTH-1:0]   a, b, res;
        logic [2*WIDTH-1:0] prod;
        bit                 wr;
        a = mReg[rs];
        b = mReg[rt];
        wr = 1'b1;
        res = '0;
        case (op)
            3'd0: res = a + b;
            3'd1: res = a - b;
            3'd2: res = a & b;
            3'd3: res = a | b;
            3'd4: begin
                prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
                res  = prod[WIDTH-1:0];
                mHi  = prod[2*WIDTH-1:WIDTH];
            end
            3'd5: res = imm;
            3'd6: res = rdata;
            default: wr = 1'b0;
        endcase
        if (wr && rd != 4'd0) mReg[rd] = res;
    endtask

    function automatic int expEdges(input logic [2:0] op, input int ackDelay);
        if (op <= 3'd3) return 3;
        if (op == 3'd4) return WIDTH + 2;
        if (op == 3'd5) return 1;
        return ackDelay + 1;
    endfunction

    task automatic applyStimulus(input logic [2:0] op, input logic [3:0] rd, rs, rt,
                                 input logic [WIDTH-1:0] imm);
        cmd_op    = op;
        cmd_rd    = rd;
        cmd_rs    = rs;
        cmd_rt    = rt;
        cmd_imm   = imm;
        cmd_valid = 1'b1;
        checkOutput("accept_ready", {31'b0, cmd_ready}, 32'd1);
        tick();
        cmd_valid = 1'b0;
        cmd_imm   = $urandom;
    endtask

    // Follows a command from its accept edge to done, acting as the memory and
    // checking bus, handshake and memory-port values along the way.
    task automatic waitDone(input string tag, input logic [2:0] op, input logic [3:0] rs, rt,
                            input logic [WIDTH-1:0] imm, input int ackDelay,
                            input logic [WIDTH-1:0] rdata);
        int edges = 0;
        int reqCycles = 0;
        bit seen = 1'b0;
        bit ackEdge = 1'b0;
        while (edges < 200) begin
            if (op <= 3'd4 && edges == 0) checkOutput({tag, "_bus_rs"}, bus_out, mReg[rs]);
            if (op <= 3'd4 && edges == 1) checkOutput({tag, "_bus_rt"}, bus_out, mReg[rt]);
            if (op == 3'd5 && edges == 0) checkOutput({tag, "_bus_imm"}, bus_out, imm);
            if (ackEdge && op == 3'd6)    checkOutput({tag, "_bus_mdr"}, bus_out, rdata);
            ackEdge = 1'b0;
            checkOutput({tag, "_busy"}, {30'b0, cmd_ready, busy}, 32'd1);
            if (mem_req) begin
                reqCycles++;
                checkOutput({tag, "_mem_we"}, {31'b0, mem_we}, {31'b0, op == 3'd7});
                checkOutput({tag, "_mem_addr"}, mem_addr, mReg[rs]);
                checkOutput({tag, "_mem_wdata"}, mem_wdata, mReg[rt]);
                if (reqCycles == ackDelay) begin
                    mem_ack   = 1'b1;
                    mem_rdata = rdata;
                    ackEdge   = 1'b1;
                end
            end
            tick();
            mem_ack   = 1'b0;
            mem_rdata = $urandom;
            edges++;
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput({tag, "_done_seen"}, {31'b0, seen}, 32'd1);
        checkOutput({tag, "_latency"}, edges, expEdges(op, ackDelay));
        if (op >= 3'd6) checkOutput({tag, "_req_cycles"}, reqCycles, ackDelay);
    endtask

    task automatic execCmd(input string tag, input logic [2:0] op, input logic [3:0] rd, rs, rt,
                           input logic [WIDTH-1:0] imm, input int ackDelay,
                           input logic [WIDTH-1:0] rdata);
        logic [WIDTH-1:0] v;
        applyStimulus(op, rd, rs, rt, imm);
        waitDone(tag, op, rs, rt, imm, ackDelay, rdata);
        modelExec(op, rd, rs, rt, imm, rdata);
        readReg(rd, v);
        checkOutput({tag, "_rd"}, v, mReg[rd]);
        checkOutput({tag, "_hi"}, hi_out, mHi);
    endtask

    initial begin
        logic [WIDTH-1:0] v;
        logic [2:0]       op;
        clear     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_rd    = '0;
        cmd_rs    = '0;
        cmd_rt    = '0;
        cmd_imm   = '0;
        mem_rdata = '0;
        mem_ack   = 1'b0;
        dbg_sel   = '0;
        modelReset();

        #120;
        checkOutput("rst_ready", {30'b0, cmd_ready, busy}, 32'd2);
        checkOutput("rst_done", {31'b0, done}, 32'd0);
        checkOutput("rst_mem", {30'b0, mem_req, mem_we}, 32'd0);
        checkOutput("rst_bus", bus_out, 32'd0);
        checkOutput("rst_hi", hi_out, 32'd0);
        tick();
        clear = 1'b1;
        tick();
        checkAllRegs("rst");

        // ALU basics with carry and borrow wrap-around
        execCmd("movi_r1", 3'd5, 4'd1, 4'd0, 4'd0, 32'hFFFF_FFFF, 0, 0);
        execCmd("movi_r2", 3'd5, 4'd2, 4'd0, 4'd0, 32'h0000_0002, 0, 0);
        execCmd("add_r3", 3'd0, 4'd3, 4'd1, 4'd2, 32'h0, 0, 0);
        readReg(3, v);
        checkOutput("add_r3_const", v, 32'h0000_0001);
        execCmd("sub_r4", 3'd1, 4'd4, 4'd2, 4'd1, 32'h0, 0, 0);
        readReg(4, v);
        checkOutput("sub_r4_const", v, 32'h0000_0003);
        tick();
        checkOutput("done_one_cycle", {31'b0, done}, 32'd0);
        checkOutput("idle_bus", bus_out, 32'd0);

        // Iterative multiply
        execCmd("mul_r5", 3'd4, 4'd5, 4'd1, 4'd2, 32'h0, 0, 0);
        readReg(5, v);
        checkOutput("mul_r5_const", v, 32'hFFFF_FFFE);
        checkOutput("mul_hi_const", hi_out, 32'h0000_0001);

        // Store then load with delayed acks, then a stray ack while idle
        execCmd("st", 3'd7, 4'd0, 4'd2, 4'd1, 32'h0, 3, 0);
        checkAllRegs("st");
        execCmd("ld_r6", 3'd6, 4'd6, 4'd2, 4'd0, 32'h0, 5, 32'hA5A5_A5A5);
        readReg(6, v);
        checkOutput("ld_r6_const", v, 32'hA5A5_A5A5);
        mem_ack   = 1'b1;
        mem_rdata = 32'h1234_5678;
        tick();
        tick();
        mem_ack = 1'b0;
        checkOutput("stray_ack_ready", {30'b0, cmd_ready, done}, 32'd2);
        checkOutput("stray_ack_req", {31'b0, mem_req}, 32'd0);
        execCmd("ld_after_stray", 3'd6, 4'd7, 4'd1, 4'd0, 32'h0, 1, 32'h0BAD_F00D);

        // Clear asserted partway through a multiply
        applyStimulus(3'd4, 4'd8, 4'd1, 4'd1, 32'h0);
        repeat (10) tick();
        checkOutput("mul_busy", {31'b0, busy}, 32'd1);
        #2;
        clear = 1'b0;
        #1;
        modelReset();
        checkOutput("abort_ready", {30'b0, cmd_ready, busy}, 32'd2);
        checkOutput("abort_mem", {31'b0, mem_req}, 32'd0);
        checkOutput("abort_hi", hi_out, 32'd0);
        checkAllRegs("abort");
        tick();
        checkOutput("abort_no_done", {31'b0, done}, 32'd0);
        clear = 1'b1;
        execCmd("post_abort", 3'd5, 4'd9, 4'd0, 4'd0, 32'hCAFE_0009, 0, 0);

        // R0 ignores writes, and a command waiting during done is taken immediately
        execCmd("movi_r0", 3'd5, 4'd0, 4'd0, 4'd0, 32'h0000_0055, 0, 0);
        checkOutput("b2b_done", {30'b0, done, cmd_ready}, 32'd3);
        execCmd("b2b_add", 3'd0, 4'd10, 4'd9, 4'd9, 32'h0, 0, 0);
        execCmd("alias_sub", 3'd1, 4'd10, 4'd10, 4'd9, 32'h0, 0, 0);

        // Random command mix
        for (int n = 0; n < 24; n++) begin
            op = 3'($urandom_range(0, 7));
            execCmd($sformatf("rnd%0d", n), op, 4'($urandom_range(0, 15)),
                    4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                    $urandom, $urandom_range(1, 4), $urandom);
        end
        checkAllRegs("final");

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
